axi2mem: RTL

AXI2MEM -- requirements
Module: axi2mem

---
 rtl/axi_lite_pkg.sv | 6 +
 rtl/axi_lite_if.sv | 23 ++
 rtl/axi2mem.sv | 94 +++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI-Lite response codes and the axi2mem FSM state encoding.
package axi_lite_pkg;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  typedef enum logic [2:0] {IDLE, WR_MEM, WR_RESP, RD_MEM, RD_RESP} state_t;
endpackage

// File: rtl/axi_lite_if.sv
// AXI_LITE: 32-bit AXI-Lite channel bundle with responder (slave) and requester (master) views.
interface AXI_LITE;
  logic [31:0] aw_addr;
  logic        aw_valid, aw_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_valid, w_ready;
  logic [1:0]  b_resp;
  logic        b_valid, b_ready;
  logic [31:0] ar_addr;
  logic        ar_valid, ar_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid, r_ready;
  modport slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
  modport master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/axi2mem.sv
// axi2mem: AXI-Lite responder issuing one transaction at a time on a native valid/ready memory port.
module axi2mem
  import axi_lite_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  AXI_LITE.slave      axi_slave,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  state_t      state, state_nxt;
  logic        live, aw_q, w_q, last_wr;
  logic [31:0] addr_q, wdata_q, rdata_q, cnt;
  logic [3:0]  wstrb_q;
  logic [1:0]  resp_q;
  logic        idle, wr_req, aw_hs, w_hs, ar_hs, wr_go, tmo, done;
  // live keeps every ready low until the first clock after reset is released
  assign idle   = live && state == IDLE;
  assign wr_req = axi_slave.aw_valid || axi_slave.w_valid;
  assign axi_slave.ar_ready = idle && !aw_q && !w_q && !(wr_req && !last_wr);
  assign ar_hs  = axi_slave.ar_ready && axi_slave.ar_valid;
  assign axi_slave.aw_ready = idle && !aw_q && !ar_hs;
  assign axi_slave.w_ready  = idle && !w_q && !ar_hs;
  assign aw_hs  = axi_slave.aw_ready && axi_slave.aw_valid;
  assign w_hs   = axi_slave.w_ready && axi_slave.w_valid;
  assign wr_go  = (aw_q || aw_hs) && (w_q || w_hs);
  assign tmo    = (TIMEOUT_CYCLES != 0) && cnt == TIMEOUT_CYCLES - 1;
  assign done   = mem_ready || tmo;
  assign mem_valid = state == WR_MEM || state == RD_MEM;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = state == WR_MEM ? wstrb_q : 4'b0000;
  assign axi_slave.b_valid = state == WR_RESP;
  assign axi_slave.b_resp  = resp_q;
  assign axi_slave.r_valid = state == RD_RESP;
  assign axi_slave.r_resp  = resp_q;
  assign axi_slave.r_data  = rdata_q;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = ar_hs ? RD_MEM : (wr_go ? WR_MEM : IDLE);
      WR_MEM:  state_nxt = done ? WR_RESP : WR_MEM;
      WR_RESP: state_nxt = axi_slave.b_ready ? IDLE : WR_RESP;
      RD_MEM:  state_nxt = done ? RD_RESP : RD_MEM;
      RD_RESP: state_nxt = axi_slave.r_ready ? IDLE : RD_RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      live    <= 1'b0;
      aw_q    <= 1'b0;
      w_q     <= 1'b0;
      last_wr <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q  <= OKAY;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
      cnt   <= (mem_valid && !done) ? cnt + 32'd1 : 32'd0;
      if (aw_hs) begin
        aw_q   <= 1'b1;
        addr_q <= axi_slave.aw_addr;
      end
      if (w_hs) begin
        w_q     <= 1'b1;
        wdata_q <= axi_slave.w_data;
        wstrb_q <= axi_slave.w_strb;
      end
      if (ar_hs) begin
        addr_q  <= axi_slave.ar_addr;
        last_wr <= 1'b0;
      end
      if (state == IDLE && state_nxt == WR_MEM) last_wr <= 1'b1;
      if (mem_valid && done) resp_q <= mem_ready ? OKAY : SLVERR;
      if (state == RD_MEM && done) rdata_q <= mem_ready ? mem_rdata : 32'h0;
      if ((axi_slave.b_valid && axi_slave.b_ready) || (axi_slave.r_valid && axi_slave.r_ready)) begin
        aw_q <= 1'b0;
        w_q  <= 1'b0;
      end
    end
  end
endmodule
